// File: rtl/el_dr_capture.sv
// el_dr_capture: synchronous consumer for a dual-rail (DR) word.
// Synchronises the raw rails, detects complete / NULL / illegal words,
// closes the 4-phase handshake on ack_o, and queues the decoded words
// in a FIFO that a Wishbone master drains through a small register map.
module el_dr_capture #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [2*WIDTH-1:0]   rail_in,
    output logic                 ack_o,
    output logic                 start_o,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_we_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    output logic                 wbs_ack_o,
    output logic [31:0]          wbs_dat_o,
    output logic                 irq_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_WAIT_NULL = 2'd2,
        ST_ERROR     = 2'd3
    } state_t;

    state_t             state;
    logic               err;
    logic               run;
    logic [15:0]        cnt;

    logic [2*WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [2*WIDTH-1:0] rails;
    logic               all_valid;
    logic               all_null;
    logic               illegal;
    logic [WIDTH-1:0]   word;

    logic [WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               full;
    logic               empty;

    logic               wb_req;
    logic               wr_ctrl;
    logic               clr_fifo;
    logic               clr_err;
    logic               push;
    logic               pop;
    logic [31:0]        rd_data;
    logic [31:0]        status;
    logic               unused_bits;

    // Rail synchroniser: SYNC_STAGES flops on every rail before any decoding.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= rail_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign rails = sync_q[SYNC_STAGES-1];

    // Word classification and decode: 01 -> 0, 10 -> 1, 00 -> NULL, 11 -> illegal.
    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        all_valid = 1'b1;
        all_null  = 1'b1;
        illegal   = 1'b0;
        word      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            all_valid = all_valid & (rails[2*i+1] ^ rails[2*i]);
            all_null  = all_null & ~(rails[2*i+1] | rails[2*i]);
            illegal   = illegal | (rails[2*i+1] & rails[2*i]);
            word[i]   = rails[2*i+1];
        end
    end

    // Wishbone request decode; writes and pops act on the edge that raises wbs_ack_o.
    assign wb_req   = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign wr_ctrl  = wb_req & wbs_we_i & (wbs_adr_i[3:2] == 2'd0);
    assign clr_fifo = wr_ctrl & wbs_dat_i[1];
    assign clr_err  = wr_ctrl & wbs_dat_i[2];
    assign pop      = wb_req & ~wbs_we_i & (wbs_adr_i[3:2] == 2'd2) & ~empty;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);

    // Capture only a complete, legal word while waiting and room is available.
    assign push = (state == ST_WAIT_DATA) & run & ~illegal & all_valid & ~full;

    // Handshake FSM; ack_o follows WAIT_NULL one cycle later and freezes in ERROR.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= ST_IDLE;
            err   <= 1'b0;
            ack_o <= 1'b0;
        end else begin
            if (state != ST_ERROR) ack_o <= (state == ST_WAIT_NULL);
            case (state)
                ST_IDLE: begin
                    if (run) state <= ST_WAIT_DATA;
                end
                ST_WAIT_DATA: begin
                    if (illegal) begin
                        state <= ST_ERROR;
                        err   <= 1'b1;
                    end else if (!run) begin
                        state <= ST_IDLE;
                    end else if (push) begin
                        state <= ST_WAIT_NULL;
                    end
                end
                ST_WAIT_NULL: begin
                    if (illegal) begin
                        state <= ST_ERROR;
                        err   <= 1'b1;
                    end else if (!run) begin
                        state <= ST_IDLE;
                    end else if (all_null) begin
                        state <= ST_WAIT_DATA;
                    end
                end
                default: begin
                    if (clr_err) begin
                        state <= ST_IDLE;
                        err   <= 1'b0;
                    end
                end
            endcase
        end
    end

    // CTRL.run; clr and clr_err are pulses and need no storage.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) run <= 1'b0;
        else if (wr_ctrl) run <= wbs_dat_i[0];
    end

    assign start_o = run;

    // FIFO pointers, occupancy and capture counter; clr wins over push/pop.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            cnt    <= '0;
        end else if (clr_fifo) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                cnt    <= cnt + 16'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage write.
    // NOTE: the storage array has no reset; occupancy guards every read of stale data.
    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr] <= word;
    end

    assign status = {cnt, 6'd0, state, 1'b0, err, full, empty, 4'(count)};

    // Register read mux.
    always_comb begin
        rd_data = '0;
        case (wbs_adr_i[3:2])
            2'd0:    rd_data = {31'd0, run};
            2'd1:    rd_data = status;
            2'd2:    rd_data = empty ? 32'd0 : 32'(mem[rd_ptr]);
            default: rd_data = '0;
        endcase
    end

    // Single-cycle Wishbone ack with read data valid only while ack is high.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= wb_req;
            wbs_dat_o <= (wb_req & ~wbs_we_i) ? rd_data : 32'd0;
        end
    end

    assign irq_o = ~empty | err;

    assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:3]};

endmodule

// File: tb/tb_el_dr_capture.sv
// Self-checking bench for el_dr_capture: directed handshake / FIFO / error /
// reset scenarios plus a randomized phase, all checked against a
// transaction-level model (word queue, capture count, err flag, FSM state).
module tb_el_dr_capture;

    localparam int W = 32;
    localparam int S = 2;
    localparam int D = 8;

    localparam logic [31:0] A_CTRL   = 32'h0;
    localparam logic [31:0] A_STATUS = 32'h4;
    localparam logic [31:0] A_DATA   = 32'h8;

    logic           clk = 1'b0;
    logic           rst;
    logic [2*W-1:0] rail;
    logic           ack;
    logic           start;
    logic           stb, cyc, we;
    logic [31:0]    adr, wdat;
    logic           wack;
    logic [31:0]    rdat;
    logic           irq;

    el_dr_capture #(.WIDTH(W), .SYNC_STAGES(S), .FIFO_DEPTH(D)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .rail_in   (rail),
        .ack_o     (ack),
        .start_o   (start),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (wack),
        .wbs_dat_o (rdat),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [31:0] q[$];
    logic [15:0] m_cnt;
    logic        m_err;
    logic [1:0]  m_state;

    int          n;
    logic [31:0] rd;
    logic [31:0] w;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] dr_encode(input logic [W-1:0] val, input logic [W-1:0] null_mask);
        logic [2*W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++)
            r[2*i +: 2] = null_mask[i] ? 2'b00 : (val[i] ? 2'b10 : 2'b01);
        return r;
    endfunction

    function automatic logic [31:0] exp_status();
        int sz;
        sz = q.size();
        return {m_cnt, 6'd0, m_state, 1'b0, m_err, (sz == D), (sz == 0), 4'(sz)};
    endfunction

    // One Wishbone transfer; entered and left at a falling edge.
    task automatic wb_xfer(input logic [31:0] a, input logic wr, input logic [31:0] d,
                           output logic [31:0] r);
        int k;
        stb = 1'b1; cyc = 1'b1; we = wr; adr = a; wdat = d;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!wack && k < 20);
        if (!wack) check("wb_ack_timeout", 0, 1);
        r = rdat;
        stb = 1'b0; cyc = 1'b0; we = 1'b0; wdat = '0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(a, 1'b1, d, dummy);
    endtask

    task automatic rd_data_chk(input string tag);
        logic [31:0] r;
        logic [31:0] e;
        wb_xfer(A_DATA, 1'b0, '0, r);
        e = (q.size() != 0) ? q.pop_front() : 32'd0;
        check(tag, r, e);
    endtask

    task automatic rd_status_chk(input string tag);
        logic [31:0] r;
        wb_xfer(A_STATUS, 1'b0, '0, r);
        check(tag, r, exp_status());
    endtask

    // Wait (bounded) for ack_o to reach a level; k counts falling edges waited.
    task automatic wait_ack(input logic level, output int k);
        k = 0;
        while (ack !== level && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (ack !== level) check("ack_wait_timeout", ack, level);
    endtask

    // Full 4-phase exchange of one word, optionally preceded by a partial word.
    task automatic send_word(input logic [31:0] val, input logic partial);
        logic [31:0] mask;
        int k;
        if (partial) begin
            mask = $urandom;
            if (mask == 0) mask = 32'h1;
            rail = dr_encode(val, mask);
            repeat (8) @(negedge clk);
            check("partial_no_ack", ack, 0);
        end
        rail = dr_encode(val, '0);
        wait_ack(1'b1, k);
        q.push_back(val);
        m_cnt = m_cnt + 16'd1;
        rail = '0;
        wait_ack(1'b0, k);
    endtask

    initial begin
        rst = 1'b1; rail = '0;
        stb = 1'b0; cyc = 1'b0; we = 1'b0; adr = '0; wdat = '0;
        m_cnt = '0; m_err = 1'b0; m_state = 2'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state.
        check("rst_ack_o", ack, 0);
        check("rst_start_o", start, 0);
        check("rst_wbs_ack", wack, 0);
        check("rst_wbs_dat", rdat, 0);
        check("rst_irq", irq, 0);
        rd_status_chk("rst_status");
        wb_xfer(A_CTRL, 1'b0, '0, rd);
        check("rst_ctrl", rd, 0);

        // T1: single word, handshake latency, readback.
        wb_write(A_CTRL, 32'h1);
        m_state = 2'd1;
        check("t1_start_o", start, 1);
        rd_status_chk("t1_status_run");
        rail = dr_encode(32'h5, '0);
        wait_ack(1'b1, n);
        check("t1_ack_rise_lat", n, S + 2);
        q.push_back(32'h5);
        m_cnt = m_cnt + 16'd1;
        rail = '0;
        wait_ack(1'b0, n);
        check("t1_ack_fall_lat", n, S + 2);
        rd_data_chk("t1_data");
        @(negedge clk);
        check("t1_wbs_ack_one_cycle", wack, 0);
        check("t1_wbs_dat_idle", rdat, 0);
        rd_status_chk("t1_status_cnt");

        // T2: fill FIFO, back-pressure, release by one pop.
        for (int i = 0; i < D; i++) send_word($urandom, 1'b0);
        rd_status_chk("t2_full_status");
        check("t2_irq", irq, 1);
        w = $urandom;
        rail = dr_encode(w, '0);
        repeat (10) @(negedge clk);
        check("t2_backpressure_ack", ack, 0);
        rd_status_chk("t2_full_hold");
        rd_data_chk("t2_pop_first");
        wait_ack(1'b1, n);
        q.push_back(w);
        m_cnt = m_cnt + 16'd1;
        rail = '0;
        wait_ack(1'b0, n);
        rd_status_chk("t2_refilled");
        for (int i = 0; i < D; i++) rd_data_chk("t2_drain");

        // T3: illegal bit -> ERROR, no push; recover with CTRL=0x5.
        rail = dr_encode($urandom, '0);
        rail[7:6] = 2'b11;
        repeat (S + 3) @(negedge clk);
        m_state = 2'd3;
        m_err = 1'b1;
        rd_status_chk("t3_error_status");
        check("t3_irq", irq, 1);
        check("t3_ack_o", ack, 0);
        rail = '0;
        wb_write(A_CTRL, 32'h5);
        m_err = 1'b0;
        m_state = 2'd1;
        rd_status_chk("t3_recovered");
        check("t3_irq_clear", irq, 0);

        // T4: empty read, then push and pop on the same edge at occupancy 3.
        rd_data_chk("t4_empty_read");
        rd_status_chk("t4_empty_status");
        for (int i = 0; i < 3; i++) send_word($urandom, 1'b0);
        w = $urandom;
        rail = dr_encode(w, '0);
        repeat (S) @(negedge clk);
        rd_data_chk("t4_pop_during_push");
        q.push_back(w);
        m_cnt = m_cnt + 16'd1;
        wait_ack(1'b1, n);
        rail = '0;
        wait_ack(1'b0, n);
        rd_status_chk("t4_occ_stays_3");

        // Randomized phase.
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    if (q.size() < D) send_word($urandom, 1'($urandom_range(0, 1)));
                    else rd_data_chk("rnd_data_full");
                end
                2: rd_data_chk("rnd_data");
                default: rd_status_chk("rnd_status");
            endcase
        end
        while (q.size() != 0) rd_data_chk("rnd_drain");

        // T6: counter wrap, then CTRL.clr while in WAIT_NULL.
        force dut.cnt = 16'hFFFE;
        @(negedge clk);
        release dut.cnt;
        m_cnt = 16'hFFFE;
        send_word($urandom, 1'b0);
        rd_status_chk("t6_cnt_ffff");
        send_word($urandom, 1'b0);
        rd_status_chk("t6_cnt_wrap");
        rail = dr_encode($urandom, '0);
        wait_ack(1'b1, n);
        wb_write(A_CTRL, 32'h3);
        q.delete();
        m_cnt = '0;
        m_state = 2'd2;
        rd_status_chk("t6_clr_keeps_state");
        rail = '0;
        wait_ack(1'b0, n);
        m_state = 2'd1;
        rd_status_chk("t6_after_clr");

        // T5: async reset in WAIT_NULL with two entries.
        send_word($urandom, 1'b0);
        w = $urandom;
        rail = dr_encode(w, '0);
        wait_ack(1'b1, n);
        q.push_back(w);
        m_cnt = m_cnt + 16'd1;
        m_state = 2'd2;
        rd_status_chk("t5_pre_reset");
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_ack_drop", ack, 0);
        check("t5_async_start_drop", start, 0);
        @(negedge clk);
        rail = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q.delete();
        m_cnt = '0;
        m_err = 1'b0;
        m_state = 2'd0;
        @(negedge clk);
        rd_status_chk("t5_post_status");
        wb_xfer(A_CTRL, 1'b0, '0, rd);
        check("t5_post_ctrl", rd, 0);
        check("t5_post_irq", irq, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
